// File: rtl/anti_theft_ctrl_pkg.sv
// Shared definitions for the anti-theft controller: FSM state encodings,
// delay-register select codes and the delay width.
package anti_theft_ctrl_pkg;

  localparam int DELAY_W = 4;

  typedef enum logic [2:0] {
    ST_ARMED       = 3'd0,
    ST_TRIGGERED   = 3'd1,
    ST_SOUND_ALARM = 3'd2,
    ST_DISARMED    = 3'd3,
    ST_WAIT_OPEN   = 3'd4,
    ST_WAIT_CLOSE  = 3'd5,
    ST_ARM_DELAY   = 3'd6
  } state_t;

  localparam logic [1:0] SEL_ARM   = 2'd0;
  localparam logic [1:0] SEL_DRV   = 2'd1;
  localparam logic [1:0] SEL_PASS  = 2'd2;
  localparam logic [1:0] SEL_ALARM = 2'd3;

endpackage

// File: rtl/anti_theft_ctrl_timer.sv
// Shared seconds timer: free-running tick divider plus a 4-bit down-counter
// that pulses expired on the Nth tick after a start.
module alarm_timer
  import anti_theft_ctrl_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               cancel,
  input  logic [DELAY_W-1:0] value,
  output logic               expired,
  output logic               tick
);

  localparam int DIV_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_HZ - 1);

  logic [DIV_W-1:0]   div;
  logic [DELAY_W-1:0] count;
  logic               running;

  assign tick    = (div == DIV_MAX);
  assign expired = running && tick && (count == DELAY_W'(1));

  // A start realigns the divider so the first tick lands a full second later.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div     <= '0;
      count   <= '0;
      running <= 1'b0;
    end else if (start) begin
      div     <= '0;
      count   <= value;
      running <= 1'b1;
    end else begin
      div <= tick ? '0 : div + DIV_W'(1);
      if (cancel) begin
        running <= 1'b0;
      end else if (running && tick) begin
        count <= count - DELAY_W'(1);
        if (count == DELAY_W'(1)) begin
          running <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/anti_theft_ctrl.sv
// Car anti-theft controller: arm/trigger/alarm FSM sharing one seconds timer,
// a programmable delay register file and an independent fuel-pump latch.
module anti_theft_ctrl
  import anti_theft_ctrl_pkg::*;
#(
  parameter int CLK_HZ      = 100_000_000,
  parameter int T_ARM_DEF   = 6,
  parameter int T_DRV_DEF   = 8,
  parameter int T_PASS_DEF  = 15,
  parameter int T_ALARM_DEF = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ignition,
  input  logic       door_driver,
  input  logic       door_pass,
  input  logic       hidden_sw,
  input  logic       brake,
  input  logic       reprogram,
  input  logic [1:0] time_sel,
  input  logic [3:0] time_value,
  output logic       status_led,
  output logic       siren,
  output logic       fuel_pump_on,
  output logic [2:0] state_out
);

  localparam logic [3:0][DELAY_W-1:0] DEFAULT_DELAY = {
    DELAY_W'(T_ALARM_DEF), DELAY_W'(T_PASS_DEF), DELAY_W'(T_DRV_DEF), DELAY_W'(T_ARM_DEF)
  };

  state_t                    state, state_nxt;
  logic [3:0][DELAY_W-1:0]   delay_q;
  logic                      led_q, led_nxt, siren_q, pump_q;
  logic                      tmr_start, tmr_cancel, tmr_expired, tmr_tick;
  logic [DELAY_W-1:0]        tmr_value;

  alarm_timer #(.CLK_HZ(CLK_HZ)) u_timer (
    .clock   (clock),
    .reset   (reset),
    .start   (tmr_start),
    .cancel  (tmr_cancel),
    .value   (tmr_value),
    .expired (tmr_expired),
    .tick    (tmr_tick)
  );

  // Writing zero restores the built-in default for that delay.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      delay_q <= DEFAULT_DELAY;
    end else if (reprogram) begin
      delay_q[time_sel] <= (time_value != '0) ? time_value : DEFAULT_DELAY[time_sel];
    end
  end

  // Next state and timer control; reprogram beats ignition beats doors beats expiry.
  always_comb begin
    state_nxt  = state;
    tmr_start  = 1'b0;
    tmr_cancel = 1'b0;
    tmr_value  = delay_q[SEL_ARM];
    if (reprogram) begin
      state_nxt  = ST_ARMED;
      tmr_cancel = 1'b1;
    end else begin
      case (state)
        ST_ARMED: begin
          if (ignition) begin
            state_nxt = ST_DISARMED;
          end else if (door_driver) begin
            state_nxt = ST_TRIGGERED;
            tmr_start = 1'b1;
            tmr_value = delay_q[SEL_DRV];
          end else if (door_pass) begin
            state_nxt = ST_TRIGGERED;
            tmr_start = 1'b1;
            tmr_value = delay_q[SEL_PASS];
          end
        end
        ST_TRIGGERED: begin
          if (ignition) begin
            state_nxt = ST_DISARMED;
          end else if (tmr_expired) begin
            state_nxt = ST_SOUND_ALARM;
            tmr_start = 1'b1;
            tmr_value = delay_q[SEL_ALARM];
          end
        end
        ST_SOUND_ALARM: begin
          if (ignition) begin
            state_nxt = ST_DISARMED;
          end else if (door_driver || door_pass) begin
            tmr_start = 1'b1;
            tmr_value = delay_q[SEL_ALARM];
          end else if (tmr_expired) begin
            state_nxt = ST_ARMED;
          end
        end
        ST_DISARMED: begin
          if (!ignition) state_nxt = ST_WAIT_OPEN;
        end
        ST_WAIT_OPEN: begin
          if (ignition)         state_nxt = ST_DISARMED;
          else if (door_driver) state_nxt = ST_WAIT_CLOSE;
        end
        ST_WAIT_CLOSE: begin
          if (ignition) begin
            state_nxt = ST_DISARMED;
          end else if (!door_driver) begin
            state_nxt = ST_ARM_DELAY;
            tmr_start = 1'b1;
            tmr_value = delay_q[SEL_ARM];
          end
        end
        ST_ARM_DELAY: begin
          if (ignition)                        state_nxt = ST_DISARMED;
          else if (door_driver || door_pass)   state_nxt = ST_WAIT_CLOSE;
          else if (tmr_expired)                state_nxt = ST_ARMED;
        end
        default: state_nxt = ST_ARMED;
      endcase
    end
  end

  // LED blinks only while resting in ARMED; entering ARMED starts it dark.
  always_comb begin
    led_nxt = 1'b0;
    case (state_nxt)
      ST_ARMED:       led_nxt = (state != ST_ARMED) ? 1'b0 : (led_q ^ tmr_tick);
      ST_TRIGGERED,
      ST_SOUND_ALARM,
      ST_ARM_DELAY:   led_nxt = 1'b1;
      default:        led_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= ST_ARMED;
      led_q   <= 1'b0;
      siren_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      led_q   <= led_nxt;
      siren_q <= (state_nxt == ST_SOUND_ALARM);
    end
  end

  // Fuel pump latches on the full key+switch+brake combination and holds with ignition.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pump_q <= 1'b0;
    end else begin
      pump_q <= ignition && (pump_q || (hidden_sw && brake));
    end
  end

  assign state_out    = state;
  assign status_led   = led_q;
  assign siren        = siren_q;
  assign fuel_pump_on = pump_q;

endmodule

// File: tb/tb_anti_theft_ctrl.sv
// Self-checking bench for anti_theft_ctrl: directed scenarios with literal
// expectations, then randomized stimulus against a deadline-based reference model.
module tb_anti_theft_ctrl;

  localparam int HZ = 4;
  localparam logic [3:0][3:0] DEF_DLY = {4'd10, 4'd15, 4'd8, 4'd6};

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       ignition = 1'b0, door_driver = 1'b0, door_pass = 1'b0;
  logic       hidden_sw = 1'b0, brake = 1'b0, reprogram = 1'b0;
  logic [1:0] time_sel = 2'd0;
  logic [3:0] time_value = 4'd0;
  logic       status_led, siren, fuel_pump_on;
  logic [2:0] state_out;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  anti_theft_ctrl #(.CLK_HZ(HZ)) dut (
    .clock        (clock),
    .reset        (reset),
    .ignition     (ignition),
    .door_driver  (door_driver),
    .door_pass    (door_pass),
    .hidden_sw    (hidden_sw),
    .brake        (brake),
    .reprogram    (reprogram),
    .time_sel     (time_sel),
    .time_value   (time_value),
    .status_led   (status_led),
    .siren        (siren),
    .fuel_pump_on (fuel_pump_on),
    .state_out    (state_out)
  );

  always #5 clock = ~clock;

  // Reference model: timer is a deadline cycle number, blink phase is an origin cycle.
  typedef struct packed {
    int              st;
    int              k;
    int              origin;
    int              deadline;
    logic            t_act;
    logic            led;
    logic            siren;
    logic            pump;
    logic [3:0][3:0] dly;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r     = '0;
    r.dly = DEF_DLY;
    return r;
  endfunction

  function automatic model_t model_next(model_t c, logic ign, logic dd, logic dp, logic hs,
                                        logic br, logic rp, logic [1:0] sel, logic [3:0] val);
    model_t n;
    logic   tick, exp, start, cancel;
    int     secs;
    n      = c;
    tick   = ((c.k - c.origin) % HZ) == HZ - 1;
    exp    = c.t_act && (c.k == c.deadline);
    start  = 1'b0;
    cancel = 1'b0;
    secs   = 0;
    if (rp) begin
      n.st       = 0;
      cancel     = 1'b1;
      n.dly[sel] = (val == 4'd0) ? DEF_DLY[sel] : val;
    end else if (ign) begin
      if (c.st != 3) n.st = 3;
      else           n.st = 3;
    end else begin
      case (c.st)
        0: if (dd) begin n.st = 1; start = 1'b1; secs = int'(c.dly[1]); end
           else if (dp) begin n.st = 1; start = 1'b1; secs = int'(c.dly[2]); end
        1: if (exp) begin n.st = 2; start = 1'b1; secs = int'(c.dly[3]); end
        2: if (dd || dp) begin start = 1'b1; secs = int'(c.dly[3]); end
           else if (exp) n.st = 0;
        3: n.st = 4;
        4: if (dd) n.st = 5;
        5: if (!dd) begin n.st = 6; start = 1'b1; secs = int'(c.dly[0]); end
        6: if (dd || dp) n.st = 5;
           else if (exp) n.st = 0;
        default: n.st = 0;
      endcase
    end
    if (start) begin
      n.t_act    = 1'b1;
      n.deadline = c.k + HZ * secs;
      n.origin   = c.k + 1;
    end else if (cancel || exp) begin
      n.t_act = 1'b0;
    end
    if (n.st == 0) n.led = (c.st != 0) ? 1'b0 : (tick ? ~c.led : c.led);
    else           n.led = (n.st == 1 || n.st == 2 || n.st == 6);
    n.siren = (n.st == 2);
    n.pump  = ign && (c.pump || (hs && br));
    n.k     = c.k + 1;
    return n;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) m <= model_reset();
    else        m <= model_next(m, ignition, door_driver, door_pass, hidden_sw, brake,
                                reprogram, time_sel, time_value);
  end

  task automatic check_output(input string name, input logic [7:0] actual,
                              input logic [7:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clock) begin
    if (reset && chk_en) begin
      check_output("model state", 8'(state_out), 8'(m.st));
      check_output("model led", 8'(status_led), 8'(m.led));
      check_output("model siren", 8'(siren), 8'(m.siren));
      check_output("model pump", 8'(fuel_pump_on), 8'(m.pump));
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic apply_stimulus(input logic ign, input logic dd, input logic dp, input logic hs,
                                input logic br, input logic rp, input logic [1:0] sel,
                                input logic [3:0] val);
    ignition    = ign;
    door_driver = dd;
    door_pass   = dp;
    hidden_sw   = hs;
    brake       = br;
    reprogram   = rp;
    time_sel    = sel;
    time_value  = val;
  endtask

  initial begin
    logic ign_l, dd_l, dp_l;
    apply_stimulus(0, 0, 0, 0, 0, 0, 2'd0, 4'd0);
    wait_cycles(3);
    check_output("reset state", 8'(state_out), 8'd0);
    check_output("reset siren", 8'(siren), 8'd0);
    check_output("reset led", 8'(status_led), 8'd0);
    check_output("reset pump", 8'(fuel_pump_on), 8'd0);
    reset  = 1'b1;
    chk_en = 1'b1;

    // Idle blink
    wait_cycles(4);
    check_output("blink on", 8'(status_led), 8'd1);
    wait_cycles(4);
    check_output("blink off", 8'(status_led), 8'd0);
    wait_cycles(32);
    check_output("idle state", 8'(state_out), 8'd0);

    // Driver door trigger, then alarm extended by an open door
    apply_stimulus(0, 1, 0, 0, 0, 0, 2'd0, 4'd0);
    wait_cycles(1);
    apply_stimulus(0, 0, 0, 0, 0, 0, 2'd0, 4'd0);
    check_output("triggered", 8'(state_out), 8'd1);
    wait_cycles(31);
    check_output("drv siren early", 8'(siren), 8'd0);
    wait_cycles(1);
    check_output("drv siren on", 8'(siren), 8'd1);
    apply_stimulus(0, 0, 1, 0, 0, 0, 2'd0, 4'd0);
    wait_cycles(20);
    apply_stimulus(0, 0, 0, 0, 0, 0, 2'd0, 4'd0);
    wait_cycles(39);
    check_output("alarm held", 8'(siren), 8'd1);
    wait_cycles(1);
    check_output("alarm ended", 8'(siren), 8'd0);
    check_output("rearmed", 8'(state_out), 8'd0);

    // Passenger door trigger
    apply_stimulus(0, 0, 1, 0, 0, 0, 2'd0, 4'd0);
    wait_cycles(1);
    apply_stimulus(0, 0, 0, 0, 0, 0, 2'd0, 4'd0);
    wait_cycles(59);
    check_output("pass siren early", 8'(siren), 8'd0);
    wait_cycles(1);
    check_output("pass siren on", 8'(siren), 8'd1);

    // Ignition silences the alarm
    apply_stimulus(1, 0, 0, 0, 0, 0, 2'd0, 4'd0);
    wait_cycles(1);
    check_output("alarm disarm", 8'(state_out), 8'd3);
    check_output("alarm disarm siren", 8'(siren), 8'd0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 2'd0, 4'd0);
    wait_cycles(1);
    check_output("wait open", 8'(state_out), 8'd4);

    // Reprogram forces ARMED; ignition during TRIGGERED disarms
    apply_stimulus(0, 0, 0, 0, 0, 1, 2'd0, 4'd0);
    wait_cycles(1);
    apply_stimulus(0, 1, 0, 0, 0, 0, 2'd0, 4'd0);
    check_output("forced armed", 8'(state_out), 8'd0);
    wait_cycles(1);
    apply_stimulus(1, 0, 0, 0, 0, 0, 2'd0, 4'd0);
    check_output("trig again", 8'(state_out), 8'd1);
    wait_cycles(1);
    check_output("trig disarm", 8'(state_out), 8'd3);
    check_output("trig disarm siren", 8'(siren), 8'd0);
    wait_cycles(2);
    apply_stimulus(0, 0, 0, 0, 0, 0, 2'd0, 4'd0);
    wait_cycles(1);
    check_output("disarm to wait", 8'(state_out), 8'd4);

    // Disarm path with a reopen during the arm delay
    apply_stimulus(0, 1, 0, 0, 0, 0, 2'd0, 4'd0);
    wait_cycles(2);
    check_output("wait close", 8'(state_out), 8'd5);
    apply_stimulus(0, 0, 0, 0, 0, 0, 2'd0, 4'd0);
    wait_cycles(1);
    check_output("arm delay", 8'(state_out), 8'd6);
    check_output("arm delay led", 8'(status_led), 8'd1);
    wait_cycles(9);
    apply_stimulus(0, 1, 0, 0, 0, 0, 2'd0, 4'd0);
    wait_cycles(1);
    check_output("reopen", 8'(state_out), 8'd5);
    apply_stimulus(0, 0, 0, 0, 0, 0, 2'd0, 4'd0);
    wait_cycles(24);
    check_output("arm delay end-1", 8'(state_out), 8'd6);
    wait_cycles(1);
    check_output("arm delay done", 8'(state_out), 8'd0);

    // Shortened driver delay, reprogram mid-alarm, default restored
    apply_stimulus(0, 0, 0, 0, 0, 1, 2'd1, 4'd2);
    wait_cycles(1);
    apply_stimulus(0, 1, 0, 0, 0, 0, 2'd0, 4'd0);
    wait_cycles(1);
    apply_stimulus(0, 0, 0, 0, 0, 0, 2'd0, 4'd0);
    wait_cycles(7);
    check_output("short siren early", 8'(siren), 8'd0);
    wait_cycles(1);
    check_output("short siren on", 8'(siren), 8'd1);
    apply_stimulus(0, 0, 0, 0, 0, 1, 2'd1, 4'd0);
    wait_cycles(1);
    apply_stimulus(0, 0, 0, 0, 0, 0, 2'd0, 4'd0);
    check_output("reprog state", 8'(state_out), 8'd0);
    check_output("reprog siren", 8'(siren), 8'd0);
    apply_stimulus(0, 1, 0, 0, 0, 0, 2'd0, 4'd0);
    wait_cycles(1);
    apply_stimulus(0, 0, 0, 0, 0, 0, 2'd0, 4'd0);
    wait_cycles(31);
    check_output("restored early", 8'(siren), 8'd0);
    wait_cycles(1);
    check_output("restored on", 8'(siren), 8'd1);

    // Fuel pump latch
    apply_stimulus(1, 0, 0, 1, 1, 0, 2'd0, 4'd0);
    wait_cycles(1);
    apply_stimulus(1, 0, 0, 0, 0, 0, 2'd0, 4'd0);
    check_output("pump set", 8'(fuel_pump_on), 8'd1);
    wait_cycles(5);
    check_output("pump held", 8'(fuel_pump_on), 8'd1);
    apply_stimulus(0, 0, 0, 0, 0, 0, 2'd0, 4'd0);
    wait_cycles(1);
    check_output("pump off", 8'(fuel_pump_on), 8'd0);
    apply_stimulus(0, 0, 0, 1, 0, 0, 2'd0, 4'd0);
    wait_cycles(1);
    check_output("pump hidden only", 8'(fuel_pump_on), 8'd0);

    // Asynchronous reset while the siren sounds
    apply_stimulus(0, 0, 0, 0, 0, 1, 2'd0, 4'd0);
    wait_cycles(1);
    apply_stimulus(0, 1, 0, 0, 0, 0, 2'd0, 4'd0);
    wait_cycles(1);
    apply_stimulus(0, 0, 0, 0, 0, 0, 2'd0, 4'd0);
    wait_cycles(32);
    check_output("pre-reset siren", 8'(siren), 8'd1);
    #2 reset = 1'b0;
    #1;
    check_output("async siren", 8'(siren), 8'd0);
    check_output("async state", 8'(state_out), 8'd0);
    check_output("async led", 8'(status_led), 8'd0);
    wait_cycles(2);
    reset = 1'b1;

    // Randomized levels with occasional reprogram pulses
    ign_l = 1'b0;
    dd_l  = 1'b0;
    dp_l  = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 3)  ign_l = ~ign_l;
      if ($urandom_range(0, 99) < 8)  dd_l  = ~dd_l;
      if ($urandom_range(0, 99) < 6)  dp_l  = ~dp_l;
      apply_stimulus(ign_l, dd_l, dp_l, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 99) < 2), 2'($urandom_range(0, 3)),
                     ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                 : 4'($urandom_range(0, 3)));
      wait_cycles(1);
    end
    apply_stimulus(0, 0, 0, 0, 0, 0, 2'd0, 4'd0);
    wait_cycles(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
